// File: rtl/double_ceil.sv
// ---------------------------------------------------------------------------
// double_ceil
//
// Pipelined IEEE-754 binary64 ceiling unit. Each cycle one raw 64-bit double
// is accepted and, two rising edges later, z = ceil(a) appears. This is the
// smallest integral double that is >= a. There is no handshake. The unit
// accepts one operand per clock and never stalls, so callers align results
// purely by latency.
//
// Ports
//   clk  in   1   rising-edge clock
//   rst  in   1   synchronous active-high reset; clears every pipeline register
//   a    in  64   operand, binary64 bit pattern
//   z    out 64   registered result, binary64 bit pattern
//
// Pipeline
//   Stage 1 classifies the operand (NaN, pass-through, |a|<1, fractional).
//   It builds the mask of mantissa bits that lie below the binary point and
//   flags whether any of those bits are set. These are registered together
//   with the operand.
//   Stage 2 truncates or increments the magnitude and registers z.
// ---------------------------------------------------------------------------
module double_ceil (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] a,
  output logic [63:0] z
);

  // Operand classes that decide how stage 2 forms the result.
  typedef enum logic [1:0] {
    CLS_PASS  = 2'd0,
    CLS_NAN   = 2'd1,
    CLS_SMALL = 2'd2,
    CLS_FRAC  = 2'd3
  } opClass_t;

  localparam logic [10:0] EXP_MAX      = 11'h7FF;
  localparam logic [10:0] EXP_BIAS_M1  = 11'd1022;
  localparam logic [10:0] EXP_LAST_FR  = 11'd1074;
  localparam logic [51:0] MANT_ONES    = {52{1'b1}};
  localparam logic [63:0] POS_ONE      = 64'h3FF0_0000_0000_0000;
  localparam logic [63:0] NEG_ZERO     = 64'h8000_0000_0000_0000;

  // Stage 1 decode signals.
  logic        aSign;
  logic [10:0] aExp;
  logic [51:0] aMant;
  logic [5:0]  shiftAmt;

  opClass_t    class_d,    class_q;
  logic [51:0] fracMask_d, fracMask_q;
  logic        hasFrac_d,  hasFrac_q;
  logic [63:0] operand_d,  operand_q;

  // Stage 2 datapath signals.
  logic [62:0] magIn;
  logic [62:0] mask63;
  logic [62:0] truncMag;
  logic [62:0] bumpMag;
  logic [63:0] z_d, z_q;

  // Stage 1 combinational decode. The operand is classified here.
  // For operands with 0 <= E <= 51, the mask of mantissa bits below the
  // binary point is built, and the flag records whether any of them is set.
  // The shift amount is E itself. Because the bias 1023 is 63 modulo 64,
  // E equals the low six exponent bits plus one, taken modulo 64. That value
  // is exact in the only range where it is used (1023..1074). This avoids an
  // 11-bit subtract.
  always_comb begin
    aSign      = a[63];
    aExp       = a[62:52];
    aMant      = a[51:0];
    shiftAmt   = aExp[5:0] + 6'd1;
    operand_d  = a;
    class_d    = CLS_PASS;
    fracMask_d = '0;

    if (aExp == EXP_MAX) begin
      class_d = (aMant != '0) ? CLS_NAN : CLS_PASS;
    end else if (aExp == '0 && aMant == '0) begin
      class_d = CLS_PASS;
    end else if (aExp <= EXP_BIAS_M1) begin
      class_d = CLS_SMALL;
    end else if (aExp <= EXP_LAST_FR) begin
      class_d    = CLS_FRAC;
      fracMask_d = MANT_ONES >> shiftAmt;
    end else begin
      class_d = CLS_PASS;
    end

    hasFrac_d = |(aMant & fracMask_d);
  end

  // Stage 1 registers. This stage holds the operand and its decode.
  // Reset clears it, which discards any operand that is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      operand_q  <= '0;
      class_q    <= CLS_PASS;
      fracMask_q <= '0;
      hasFrac_q  <= 1'b0;
    end else begin
      operand_q  <= operand_d;
      class_q    <= class_d;
      fracMask_q <= fracMask_d;
      hasFrac_q  <= hasFrac_d;
    end
  end

  // Stage 2 combinational result. Truncation clears the fractional bits.
  // For positive operands, the value is then bumped by one integer unit,
  // which is 1<<(52-E). That unit is exactly fracMask+1, so no second
  // shifter is needed. The add works on the whole {exponent, mantissa}
  // field, so a carry out of the mantissa raises the exponent. For example,
  // 3.75 becomes 4.0.
  always_comb begin
    magIn    = operand_q[62:0];
    mask63   = {11'b0, fracMask_q};
    truncMag = magIn & ~mask63;
    bumpMag  = truncMag + mask63 + 63'd1;
    z_d      = operand_q;

    unique case (class_q)
      CLS_PASS: begin
        z_d = operand_q;
      end
      CLS_NAN: begin
        z_d = {operand_q[63:52], 1'b1, operand_q[50:0]};
      end
      CLS_SMALL: begin
        z_d = operand_q[63] ? NEG_ZERO : POS_ONE;
      end
      CLS_FRAC: begin
        if (!hasFrac_q) begin
          z_d = operand_q;
        end else if (operand_q[63]) begin
          z_d = {1'b1, truncMag};
        end else begin
          z_d = {1'b0, bumpMag};
        end
      end
      default: begin
        z_d = operand_q;
      end
    endcase
  end

  // Stage 2 register. This drives z. Reset forces +0.0.
  always_ff @(posedge clk) begin
    if (rst) begin
      z_q <= '0;
    end else begin
      z_q <= z_d;
    end
  end

  assign z = z_q;

endmodule

// File: tb/tb_double_ceil.sv
// ---------------------------------------------------------------------------
// tb_double_ceil
//
// Directed and random vectors for double_ceil. Operands are driven on the
// falling edge, and z is sampled on the falling edge as well. A result is
// compared two falling edges after its operand was applied. That is two
// rising edges of latency. Directed expectations are hand computed. The
// random ones come from a real-arithmetic ceil reference.
// ---------------------------------------------------------------------------
module tb_double_ceil;

  logic        clk;
  logic        rst;
  logic [63:0] a;
  logic [63:0] z;

  int errorCount;
  int checkCount;

  // Expectations in flight. Slot 1 is compared on the next falling edge.
  logic [63:0] pendExp   [2];
  logic        pendValid [2];
  string       pendTag   [2];

  double_ceil dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .z   (z)
  );

  // Free-running clock with a 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compares one observed value against its expectation and records it.
  task automatic checkOutput(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // On a falling edge: check the result of the operand applied two edges
  // earlier, shift the expectation pipe, then drive the new operand.
  task automatic applyStimulus(input string tag, input logic [63:0] val,
                               input logic [63:0] exp);
    @(negedge clk);
    if (pendValid[1]) checkOutput(pendTag[1], z, pendExp[1]);
    pendExp[1]   = pendExp[0];
    pendValid[1] = pendValid[0];
    pendTag[1]   = pendTag[0];
    pendExp[0]   = exp;
    pendValid[0] = 1'b1;
    pendTag[0]   = tag;
    a = val;
  endtask

  // Reference ceil built on real arithmetic. It is only used for finite,
  // non-NaN operands.
  function automatic logic [63:0] ceilRef(input logic [63:0] x);
    real r;
    r = $bitstoreal(x);
    return $realtobits($ceil(r));
  endfunction

  initial begin
    logic [63:0] rv;
    logic [10:0] rexp;
    errorCount = 0;
    checkCount = 0;
    for (int i = 0; i < 2; i++) begin
      pendExp[i]   = '0;
      pendValid[i] = 1'b0;
      pendTag[i]   = "";
    end

    // Reset held across two rising edges, with junk on a.
    rst = 1'b1;
    a   = 64'hDEAD_BEEF_1234_5678;
    @(negedge clk);
    a = 64'h3FF8_0000_0000_0000;
    @(negedge clk);
    checkOutput("reset_z", z, 64'h0);

    // Release. The first rising edge flushes the reset-cleared stage, which
    // gives z = 0. The next one delivers ceil(1.5).
    rst = 1'b0;
    a   = 64'h3FF8_0000_0000_0000;
    pendExp[0] = 64'h4000_0000_0000_0000; pendValid[0] = 1'b1; pendTag[0] = "first_1p5";
    pendExp[1] = 64'h0;                   pendValid[1] = 1'b1; pendTag[1] = "reset_flush";

    // Directed, back-to-back.
    applyStimulus("pos_2p5",      64'h4004_0000_0000_0000, 64'h4008_0000_0000_0000);
    applyStimulus("pos_3p75",     64'h400E_0000_0000_0000, 64'h4010_0000_0000_0000);
    applyStimulus("neg_1p5",      64'hBFF8_0000_0000_0000, 64'hBFF0_0000_0000_0000);
    applyStimulus("neg_0p25",     64'hBFD0_0000_0000_0000, 64'h8000_0000_0000_0000);
    applyStimulus("min_subnorm",  64'h0000_0000_0000_0001, 64'h3FF0_0000_0000_0000);
    applyStimulus("pos_0p5",      64'h3FE0_0000_0000_0000, 64'h3FF0_0000_0000_0000);
    applyStimulus("one_pass",     64'h3FF0_0000_0000_0000, 64'h3FF0_0000_0000_0000);
    applyStimulus("two52_pass",   64'h4330_0000_0000_0000, 64'h4330_0000_0000_0000);
    applyStimulus("pinf_pass",    64'h7FF0_0000_0000_0000, 64'h7FF0_0000_0000_0000);
    applyStimulus("nzero_pass",   64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
    applyStimulus("ninf_pass",    64'hFFF0_0000_0000_0000, 64'hFFF0_0000_0000_0000);
    applyStimulus("snan_quiet",   64'h7FF0_0000_0000_0001, 64'h7FF8_0000_0000_0001);
    applyStimulus("neg_snan",     64'hFFF0_0000_0000_0001, 64'hFFF8_0000_0000_0001);
    applyStimulus("qnan_pass",    64'h7FF8_0000_0000_0000, 64'h7FF8_0000_0000_0000);
    applyStimulus("e51_pos_carry",64'h432F_FFFF_FFFF_FFFF, 64'h4330_0000_0000_0000);
    applyStimulus("e51_neg_trunc",64'hC32F_FFFF_FFFF_FFFF, 64'hC32F_FFFF_FFFF_FFFE);
    applyStimulus("neg_subnorm",  64'h800F_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000);
    applyStimulus("pzero_pass",   64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000);
    applyStimulus("neg_2p0_pass", 64'hC000_0000_0000_0000, 64'hC000_0000_0000_0000);

    // Random finite operands clustered around the interesting exponents.
    for (int i = 0; i < 60; i++) begin
      rexp = 11'($urandom_range(1000, 1090));
      rv   = {1'($urandom_range(0, 1)), rexp, 20'($urandom), 32'($urandom)};
      applyStimulus($sformatf("rand_%0d", i), rv, ceilRef(rv));
    end

    // Drain the two operands still in flight.
    applyStimulus("drain_0", 64'h0, 64'h0);
    applyStimulus("drain_1", 64'h0, 64'h0);
    applyStimulus("drain_2", 64'h0, 64'h0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
